seg7_number_ctrl: RTL and testbench



---
 rtl/seg7_number_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seg7_number_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_number_ctrl.sv
// Binary-to-BCD sequencer for a bank of 7-segment decoders, with a serial double-dabble engine.
// The optional saturate-on-overflow display is enabled with the SEG7_OVERFLOW_EN macro.
module seg7_number_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_value,
    input  logic                  blank_zeros,
    output logic                  busy,
    output logic                  update,
    output logic [DIGITS-1:0]     digit_en,
    output logic [4*DIGITS-1:0]   digit_num
`ifdef SEG7_OVERFLOW_EN
    ,
    output logic                  overflow
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              blank_q, blank_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DIGITS-1:0] digit_en_q, digit_en_d;
    logic [BW-1:0]     digit_num_q, digit_num_d;
    logic              update_q, update_d;
    logic [BW-1:0]     bcd_adj;
    logic [DIGITS-1:0] en_calc;
    logic              any_nz;

`ifdef SEG7_OVERFLOW_EN
    localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);
    logic ovf_flag_q, ovf_flag_d;
    logic overflow_q, overflow_d;
    logic [63:0] in_ext;
    assign in_ext   = 64'(in_value);
    assign overflow = overflow_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign update    = update_q;
    assign digit_en  = digit_en_q;
    assign digit_num = digit_num_q;

    // Add-3 correction applied to every BCD digit before each shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A digit is lit unless it and every more significant digit are zero
    always_comb begin
        any_nz  = 1'b0;
        en_calc = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz     = any_nz | (|bcd_q[4*i +: 4]);
            en_calc[i] = !blank_q || any_nz || (i == 0);
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        cnt_d       = cnt_q;
        digit_en_d  = digit_en_q;
        digit_num_d = digit_num_q;
        update_d    = 1'b0;
`ifdef SEG7_OVERFLOW_EN
        ovf_flag_d  = ovf_flag_q;
        overflow_d  = overflow_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_value;
                    bcd_d   = '0;
                    blank_d = blank_zeros;
                    cnt_d   = CW'(WIDTH - 1);
`ifdef SEG7_OVERFLOW_EN
                    ovf_flag_d = (in_ext > MAX_VAL);
`endif
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                digit_num_d = bcd_q;
                digit_en_d  = en_calc;
                update_d    = 1'b1;
`ifdef SEG7_OVERFLOW_EN
                overflow_d  = ovf_flag_q;
                if (ovf_flag_q) begin
                    digit_num_d = {DIGITS{4'h9}};
                    digit_en_d  = '1;
                end
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            blank_q     <= 1'b0;
            cnt_q       <= '0;
            digit_en_q  <= '0;
            digit_num_q <= '0;
            update_q    <= 1'b0;
`ifdef SEG7_OVERFLOW_EN
            ovf_flag_q  <= 1'b0;
            overflow_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            cnt_q       <= cnt_d;
            digit_en_q  <= digit_en_d;
            digit_num_q <= digit_num_d;
            update_q    <= update_d;
`ifdef SEG7_OVERFLOW_EN
            ovf_flag_q  <= ovf_flag_d;
            overflow_q  <= overflow_d;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_number_ctrl.sv
// Randomized self-checking bench for seg7_number_ctrl against a decimal-arithmetic display model.
// Compile with SEG7_OVERFLOW_EN defined to exercise the saturating overflow display.
module tb_seg7_number_ctrl;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 4;

    logic                clk;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_value;
    logic                blank_zeros;
    logic                busy;
    logic                update;
    logic [DIGITS-1:0]   digit_en;
    logic [4*DIGITS-1:0] digit_num;
`ifdef SEG7_OVERFLOW_EN
    logic                overflow;
    logic                prevOvf;
`endif

    int passCount;
    int checkCount;
    logic [4*DIGITS-1:0] prevNum;
    logic [DIGITS-1:0]   prevEn;

    seg7_number_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .blank_zeros(blank_zeros),
        .busy       (busy),
        .update     (update),
        .digit_en   (digit_en),
        .digit_num  (digit_num)
`ifdef SEG7_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through here
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Display contents computed with plain decimal arithmetic
    function automatic void modelDisplay(input longint unsigned value, input logic blank,
                                         output logic [4*DIGITS-1:0] num,
                                         output logic [DIGITS-1:0] en, output logic ovf);
        longint unsigned lim;
        longint unsigned v;
        int top;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        ovf = 1'b0;
`ifdef SEG7_OVERFLOW_EN
        if (value >= lim) ovf = 1'b1;
`endif
        num = '0;
        en  = '0;
        if (ovf) begin
            for (int i = 0; i < DIGITS; i++) num[4*i +: 4] = 4'h9;
            en = '1;
        end else begin
            v   = value % lim;
            top = 0;
            for (int i = 0; i < DIGITS; i++) begin
                num[4*i +: 4] = 4'(v % 10);
                if ((v % 10) != 0) top = i;
                v = v / 10;
            end
            for (int i = 0; i < DIGITS; i++) en[i] = !blank || (i <= top);
        end
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] value, input logic blank);
        logic [4*DIGITS-1:0] expNum;
        logic [DIGITS-1:0]   expEn;
        logic                expOvf;
        int waits;
        int n;
        int readyBad;
        int unstable;
        modelDisplay(longint'(value), blank, expNum, expEn, expOvf);
        in_value    = value;
        blank_zeros = blank;
        in_valid    = 1'b1;
        waits = 0;
        while (!in_ready && waits < 100) begin
            stepCycle();
            waits++;
        end
        checkOutput("ready_wait", 64'(waits < 100), 64'd1);
        stepCycle();
        in_valid    = 1'b0;
        in_value    = WIDTH'($urandom);
        blank_zeros = 1'($urandom);
        n = 0;
        readyBad = 0;
        unstable = 0;
        do begin
            if (in_ready) readyBad++;
            stepCycle();
            n++;
            if (!update) begin
                if (digit_num !== prevNum || digit_en !== prevEn) unstable++;
            end
        end while (!update && n < 40);
        checkOutput("latency", 64'(n), 64'd17);
        checkOutput("ready_low", 64'(readyBad), 64'd0);
        checkOutput("stable", 64'(unstable), 64'd0);
        checkOutput("digit_num", 64'(digit_num), 64'(expNum));
        checkOutput("digit_en", 64'(digit_en), 64'(expEn));
        checkOutput("ready_after", 64'(in_ready), 64'd1);
`ifdef SEG7_OVERFLOW_EN
        checkOutput("overflow", 64'(overflow), 64'(expOvf));
        prevOvf = expOvf;
`endif
        stepCycle();
        checkOutput("update_1cyc", 64'(update), 64'd0);
        prevNum = expNum;
        prevEn  = expEn;
    endtask

    initial begin
        int accepts;
        int pulses;
        int cyc;
        int pulseCyc[2];
        int spurious;
        logic hs;
        logic [4*DIGITS-1:0] eNum;
        logic [DIGITS-1:0]   eEn;
        logic                eOvf;

        passCount   = 0;
        checkCount  = 0;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_value    = '0;
        blank_zeros = 1'b0;
        prevNum     = '0;
        prevEn      = '0;
        repeat (3) stepCycle();
        reset_n = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rst_en", 64'(digit_en), 64'd0);
        checkOutput("rst_num", 64'(digit_num), 64'd0);
        checkOutput("rst_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_update", 64'(update), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
`ifdef SEG7_OVERFLOW_EN
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
`endif

        applyStimulus(16'd1234, 1'b0);
        applyStimulus(16'd7, 1'b1);
        applyStimulus(16'd0, 1'b1);
        applyStimulus(16'd305, 1'b1);
        applyStimulus(16'd65535, 1'b0);
        applyStimulus(16'd42, 1'b0);
        applyStimulus(16'd10000, 1'b1);
        applyStimulus(16'd9999, 1'b1);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 0) applyStimulus(WIDTH'($urandom_range(0, 65535)), 1'($urandom));
            else applyStimulus(WIDTH'($urandom_range(0, 200)), 1'($urandom));
        end

        // Hold in_valid across the conversion; the second value waits for in_ready
        in_value    = 16'd1;
        blank_zeros = 1'b0;
        in_valid    = 1'b1;
        accepts  = 0;
        pulses   = 0;
        cyc      = 0;
        pulseCyc[0] = 0;
        pulseCyc[1] = 0;
        while (pulses < 2 && cyc < 100) begin
            hs = in_valid && in_ready;
            stepCycle();
            cyc++;
            if (hs) begin
                accepts++;
                if (accepts == 1) in_value = 16'd2;
                else in_valid = 1'b0;
            end
            if (update) begin
                modelDisplay(longint'(pulses + 1), 1'b0, eNum, eEn, eOvf);
                checkOutput("hold_num", 64'(digit_num), 64'(eNum));
                pulseCyc[pulses] = cyc;
                pulses++;
                prevNum = eNum;
                prevEn  = eEn;
            end
        end
        in_valid = 1'b0;
        checkOutput("hold_pulses", 64'(pulses), 64'd2);
        checkOutput("hold_gap", 64'(pulseCyc[1] - pulseCyc[0]), 64'd18);
        stepCycle();

        // Reset in the middle of a conversion drops the value and blanks the display
        applyStimulus(16'd1234, 1'b0);
        in_value = 16'd9999;
        in_valid = 1'b1;
        stepCycle();
        in_valid = 1'b0;
        repeat (5) stepCycle();
        checkOutput("pre_rst_num", 64'(digit_num), 64'h1234);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_en", 64'(digit_en), 64'd0);
        checkOutput("midrst_num", 64'(digit_num), 64'd0);
        repeat (2) stepCycle();
        reset_n = 1'b1;
        stepCycle();
        checkOutput("midrst_ready", 64'(in_ready), 64'd1);
        spurious = 0;
        for (int k = 0; k < 25; k++) begin
            if (update) spurious++;
            stepCycle();
        end
        checkOutput("midrst_noupd", 64'(spurious), 64'd0);
        prevNum = '0;
        prevEn  = '0;
`ifdef SEG7_OVERFLOW_EN
        prevOvf = 1'b0;
`endif
        applyStimulus(16'd42, 1'b1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
